// File: rtl/gate_tt_checker.sv
// Response checker for a 2-input gate: compares sampled {a,b,y} against truth table TT,
// counts mismatches, tracks input coverage and reports pass/fail at the end of a run.
module gate_tt_checker #(
    parameter logic [3:0]  TT      = 4'b1001,
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       coverage,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       cov_q, cov_d;
    logic [1:0]       ffv_q, ffv_d;
    logic             ffval_q, ffval_d;
    logic             mm_q, mm_d;
    logic             to_q, to_d;
    logic [1:0]       idx;
    logic             fail;

    assign idx = {a, b};
    // !== makes an X/Z on y count as a failure in simulation.
    assign fail = sample_valid && (y !== TT[idx]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cov_d   = cov_q;
        ffv_d   = ffv_q;
        ffval_d = ffval_q;
        mm_d    = 1'b0;
        to_d    = to_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    err_d   = '0;
                    cov_d   = '0;
                    ffv_d   = '0;
                    ffval_d = 1'b0;
                    to_d    = 1'b0;
                end
            end
            StRun: begin
                if (sample_valid) begin
                    cov_d = cov_q | (4'b0001 << idx);
                    mm_d  = fail;
                    if (fail && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (fail && !ffval_q) begin
                        ffv_d   = idx;
                        ffval_d = 1'b1;
                    end
                end
                // Coverage completion takes priority over a coincident timeout.
                if (cov_d == 4'hF) begin
                    state_d = StDone;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= '0;
            cov_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            mm_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cov_q   <= cov_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
            mm_q    <= mm_d;
            to_q    <= to_d;
        end
    end

    assign busy             = (state_q == StRun);
    assign done             = (state_q == StDone);
    assign pass             = done && (err_q == '0) && (cov_q == 4'hF) && !to_q;
    assign timeout          = to_q;
    assign mismatch         = mm_q;
    assign err_count        = err_q;
    assign coverage         = cov_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule
